// File: rtl/chip_interface.sv
// chip_interface: push-button password lock. Button edge detection, 6-digit entry and
// compare, PASS/FAIL display, escalating lockout, inactivity timeout and password-table select.
module chip_interface #(
  parameter int unsigned FRE           = 50_000_000,
  parameter int unsigned PASS_TICKS    = 6,
  parameter int unsigned FAIL_TICKS    = 6,
  parameter int unsigned LOCK_BASE     = 15,
  parameter int unsigned TIMEOUT_TICKS = 60,
  parameter int unsigned TO_SHOW_TICKS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter0,
  input  logic       enter1,
  input  logic       confirm,
  input  logic       clear,
  input  logic       algorithm_select_mode,
  output logic [5:0] led
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL_AUTH,
    ST_PASS,
    ST_FAIL,
    ST_LOCK,
    ST_MODE_SEL,
    ST_TIMEOUT
  } state_e;

  localparam int unsigned PASS_CYC  = PASS_TICKS * FRE;
  localparam int unsigned FAIL_CYC  = FAIL_TICKS * FRE;
  localparam int unsigned LOCK1_CYC = LOCK_BASE * FRE;
  localparam int unsigned LOCK2_CYC = 2 * LOCK_BASE * FRE;
  localparam int unsigned LOCK4_CYC = 4 * LOCK_BASE * FRE;
  localparam int unsigned TO_CYC    = TIMEOUT_TICKS * FRE;
  localparam int unsigned TOS_CYC   = TO_SHOW_TICKS * FRE;

  localparam logic [5:0] LED_PASS    = 6'b100001;
  localparam logic [5:0] LED_FAIL    = 6'b101010;
  localparam logic [5:0] LED_LOCK    = 6'b010101;
  localparam logic [5:0] LED_TIMEOUT = 6'b011110;

  // Button vector bit order: 4 clear, 3 confirm, 2 select, 1 enter1, 0 enter0
  logic [4:0]  btn_raw;
  logic [4:0]  sync1_q, sync1_d;
  logic [4:0]  sync2_q, sync2_d;
  logic [4:0]  prev_q, prev_d;
  logic [4:0]  rise;

  logic        ev_clear, ev_confirm, ev_select, ev_digit, ev_bit;

  state_e      state_q, state_d;
  logic [5:0]  ent_q, ent_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [1:0]  fail_q, fail_d;
  logic        to_mode_q, to_mode_d;
  logic [31:0] timer_q, timer_d;
  logic [5:0]  led_q, led_d;

  logic [5:0]  pw;
  logic        pw_valid;
  logic [31:0] lock_len;
  logic        accepted;

  // Two-stage synchronizer feeding a rising-edge detector
  always_comb begin
    btn_raw = {clear, confirm, algorithm_select_mode, enter1, enter0};
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
  end

  // Keep only the highest-priority event of a cycle
  always_comb begin
    ev_clear   = 1'b0;
    ev_confirm = 1'b0;
    ev_select  = 1'b0;
    ev_digit   = 1'b0;
    ev_bit     = 1'b0;
    if (rise[4]) begin
      ev_clear = 1'b1;
    end else if (rise[3]) begin
      ev_confirm = 1'b1;
    end else if (rise[2]) begin
      ev_select = 1'b1;
    end else if (rise[1]) begin
      ev_digit = 1'b1;
      ev_bit   = 1'b1;
    end else if (rise[0]) begin
      ev_digit = 1'b1;
    end
  end

  // Active password table and lockout length
  always_comb begin
    pw       = '0;
    pw_valid = 1'b1;
    case (code_q)
      3'b000:  pw = 6'b101101;
      3'b001:  pw = 6'b110100;
      3'b010:  pw = 6'b011010;
      3'b011:  pw = 6'b100111;
      default: pw_valid = 1'b0;
    endcase
    case (fail_q)
      2'd1:    lock_len = LOCK1_CYC;
      2'd2:    lock_len = LOCK2_CYC;
      default: lock_len = LOCK4_CYC;
    endcase
  end

  // Next state, entry buffer and counters. One timer serves as display timer in the
  // display states and as inactivity timer in the entry states; it restarts on every
  // state change and on every accepted event.
  always_comb begin
    state_d   = state_q;
    ent_d     = ent_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    fail_d    = fail_q;
    to_mode_d = to_mode_q;
    timer_d   = timer_q + 32'd1;
    accepted  = 1'b0;

    case (state_q)
      ST_IDLE, ST_SEL_AUTH: begin
        if (ev_clear) begin
          accepted = 1'b1;
          ent_d    = '0;
          cnt_d    = '0;
        end else if (ev_confirm) begin
          accepted = 1'b1;
          if (cnt_q == 3'd6 && pw_valid && ent_q == pw) begin
            state_d   = ST_PASS;
            to_mode_d = (state_q == ST_SEL_AUTH);
          end else begin
            state_d = ST_FAIL;
          end
        end else if (ev_select && state_q == ST_IDLE) begin
          accepted = 1'b1;
          state_d  = ST_SEL_AUTH;
        end else if (ev_digit) begin
          accepted = 1'b1;
          ent_d    = {ent_q[4:0], ev_bit};
          cnt_d    = (cnt_q == 3'd6) ? 3'd6 : cnt_q + 3'd1;
        end else if (timer_q == TO_CYC - 1) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_MODE_SEL: begin
        if (ev_clear) begin
          accepted = 1'b1;
          ent_d    = '0;
          cnt_d    = '0;
        end else if (ev_confirm) begin
          accepted = 1'b1;
          if (cnt_q >= 3'd3 && !ent_q[2]) begin
            code_d = ent_q[2:0];
          end
          state_d = ST_IDLE;
        end else if (ev_digit) begin
          accepted = 1'b1;
          ent_d    = {ent_q[4:0], ev_bit};
          cnt_d    = (cnt_q == 3'd6) ? 3'd6 : cnt_q + 3'd1;
        end else if (timer_q == TO_CYC - 1) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS: begin
        if (timer_q == PASS_CYC - 1) begin
          state_d = to_mode_q ? ST_MODE_SEL : ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (timer_q == FAIL_CYC - 1) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (timer_q == lock_len - 32'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_TIMEOUT: begin
        if (timer_q == TOS_CYC - 1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accepted) begin
      timer_d = '0;
    end

    if (state_d != state_q) begin
      timer_d = '0;
      case (state_d)
        ST_IDLE, ST_SEL_AUTH, ST_MODE_SEL, ST_TIMEOUT: begin
          ent_d = '0;
          cnt_d = '0;
        end
        ST_PASS: fail_d = '0;
        ST_FAIL: fail_d = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Display derived from the upcoming state so the registered LED tracks the state register
  always_comb begin
    led_d = '0;
    case (state_d)
      ST_IDLE, ST_SEL_AUTH: begin
        for (int unsigned i = 0; i < 6; i++) begin
          led_d[i] = ({29'd0, cnt_d} > i);
        end
      end
      ST_MODE_SEL: led_d = {3'b110, ent_d[2:0]};
      ST_PASS:     led_d = LED_PASS;
      ST_FAIL:     led_d = LED_FAIL;
      ST_LOCK:     led_d = LED_LOCK;
      ST_TIMEOUT:  led_d = LED_TIMEOUT;
      default:     led_d = '0;
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      state_q   <= ST_IDLE;
      ent_q     <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      fail_q    <= '0;
      to_mode_q <= 1'b0;
      timer_q   <= '0;
      led_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      ent_q     <= ent_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      fail_q    <= fail_d;
      to_mode_q <= to_mode_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_chip_interface.sv
// tb_chip_interface: directed and randomized sequences against a queue-based lock model.
module tb_chip_interface;

  localparam int unsigned FRE    = 6;
  localparam int unsigned PASS_T = 6;
  localparam int unsigned FAIL_T = 6;
  localparam int unsigned LOCK_B = 15;
  localparam int unsigned TO_T   = 60;
  localparam int unsigned TOS_T  = 1;

  localparam logic [5:0] L_PASS = 6'b100001;
  localparam logic [5:0] L_FAIL = 6'b101010;
  localparam logic [5:0] L_LOCK = 6'b010101;
  localparam logic [5:0] L_TO   = 6'b011110;

  // masks: {clear, confirm, select, enter1, enter0}
  localparam logic [4:0] M_E0   = 5'b00001;
  localparam logic [4:0] M_E1   = 5'b00010;
  localparam logic [4:0] M_SEL  = 5'b00100;
  localparam logic [4:0] M_CONF = 5'b01000;
  localparam logic [4:0] M_CLR  = 5'b10000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter0 = 1'b0;
  logic       enter1 = 1'b0;
  logic       confirm = 1'b0;
  logic       clear = 1'b0;
  logic       algorithm_select_mode = 1'b0;
  logic [5:0] led;

  chip_interface #(
    .FRE(FRE),
    .PASS_TICKS(PASS_T),
    .FAIL_TICKS(FAIL_T),
    .LOCK_BASE(LOCK_B),
    .TIMEOUT_TICKS(TO_T),
    .TO_SHOW_TICKS(TOS_T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enter0(enter0),
    .enter1(enter1),
    .confirm(confirm),
    .clear(clear),
    .algorithm_select_mode(algorithm_select_mode),
    .led(led)
  );

  always #5 clock = ~clock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // reference model: digits entered (oldest first), active code, failure count, mode flags
  int unsigned dq[$];
  int unsigned m_code = 0;
  int unsigned m_fail = 0;
  bit          m_sel_auth = 1'b0;
  bit          m_mode_sel = 1'b0;
  int unsigned pw_tab [4] = '{45, 52, 26, 39};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int unsigned thermo(input int unsigned n);
    return (1 << n) - 1;
  endfunction

  function automatic int unsigned dq_value();
    int unsigned v = 0;
    foreach (dq[i]) v = v * 2 + dq[i];
    return v;
  endfunction

  function automatic int unsigned dq_last3();
    int unsigned v = 0;
    int unsigned sz = dq.size();
    int unsigned st = (sz > 3) ? sz - 3 : 0;
    for (int unsigned i = st; i < sz; i++) v = v * 2 + dq[i];
    return v;
  endfunction

  function automatic int unsigned exp_entry_led();
    if (m_mode_sel) return 48 + dq_last3();
    return thermo(dq.size());
  endfunction

  task automatic set_buttons(input logic [4:0] m);
    {clear, confirm, algorithm_select_mode, enter1, enter0} = m;
  endtask

  task automatic press(input logic [4:0] m);
    set_buttons(m);
    repeat (3) @(negedge clock);
    set_buttons('0);
    repeat (3) @(negedge clock);
  endtask

  task automatic push_digit(input bit d);
    dq.push_back(d);
    if (dq.size() > 6) void'(dq.pop_front());
  endtask

  task automatic digit(input bit d, input string tag);
    press(d ? M_E1 : M_E0);
    push_digit(d);
    chk(tag, led, exp_entry_led());
  endtask

  task automatic enter_bits(input int unsigned v, input int unsigned n, input string tag);
    for (int i = int'(n) - 1; i >= 0; i--) digit(bit'((v >> i) & 1), tag);
  endtask

  task automatic clear_entry(input string tag);
    press(M_CLR);
    dq.delete();
    chk(tag, led, exp_entry_led());
  endtask

  task automatic select_btn(input string tag);
    press(M_SEL);
    if (!m_sel_auth && !m_mode_sel) begin
      m_sel_auth = 1'b1;
      dq.delete();
    end
    chk(tag, led, exp_entry_led());
  endtask

  // Counts consecutive cycles the display holds exp, optionally pressing buttons meanwhile
  task automatic hold_check(input logic [5:0] exp, input int unsigned exp_len,
                            input string tag, input bit poke);
    int unsigned len;
    logic [4:0]  pm;
    len = 0;
    pm  = 5'($urandom_range(1, 31));
    while (led === exp && len < exp_len + 20) begin
      if (poke) set_buttons((len % 6 < 3 && len + 12 < exp_len) ? pm : 5'b0);
      @(negedge clock);
      len++;
    end
    set_buttons('0);
    chk(tag, len, exp_len);
  endtask

  task automatic confirm_step(input logic [4:0] mask, input string tag);
    int unsigned t;
    logic [5:0]  disp;
    bit          ok;
    if (m_mode_sel) begin
      press(mask);
      if (dq.size() >= 3 && dq_last3() < 4) m_code = dq_last3();
      m_mode_sel = 1'b0;
      dq.delete();
      chk({tag, " idle"}, led, 0);
    end else begin
      ok   = (dq.size() == 6) && (dq_value() == pw_tab[m_code]);
      disp = ok ? L_PASS : L_FAIL;
      t    = 0;
      set_buttons(mask);
      while (led !== disp && t < 12) begin
        @(negedge clock);
        t++;
        if (t == 3) set_buttons('0);
      end
      set_buttons('0);
      chk({tag, " display"}, led, disp);
      if (ok) begin
        m_fail = 0;
        hold_check(L_PASS, PASS_T * FRE, {tag, " pass len"}, 1'b0);
        if (m_sel_auth) m_mode_sel = 1'b1;
      end else begin
        m_fail = (m_fail == 3) ? 3 : m_fail + 1;
        hold_check(L_FAIL, FAIL_T * FRE, {tag, " fail len"}, 1'b0);
        hold_check(L_LOCK, LOCK_B * FRE * (1 << (m_fail - 1)), {tag, " lock len"}, 1'b1);
      end
      m_sel_auth = 1'b0;
      dq.delete();
      chk({tag, " after"}, led, exp_entry_led());
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    int unsigned nd;
    int unsigned kind;
    int unsigned extra;

    set_buttons('0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset led", led, 0);
    reset = 1'b0;

    // idle inactivity timeout straight after reset
    hold_check(6'b0, TO_T * FRE, "idle until timeout", 1'b0);
    hold_check(L_TO, TOS_T * FRE, "timeout display", 1'b0);
    chk("idle after timeout", led, 0);

    // default password
    enter_bits(45, 6, "pw digit");
    confirm_step(M_CONF, "pw ok");

    // escalating lockout, fourth failure saturates; short entry fails
    enter_bits(63, 6, "bad digit");
    confirm_step(M_CONF, "fail1");
    for (int r = 0; r < 2; r++) begin
      do v = $urandom_range(0, 63); while (v == 45);
      enter_bits(v, 6, "bad digit");
      confirm_step(M_CONF, "failN");
    end
    enter_bits(22, 5, "short digit");
    confirm_step(M_CONF, "fail short sat");

    // clear, priorities, then pass
    digit(1'b1, "t4 d1");
    digit(1'b0, "t4 d2");
    chk("two digits", led, 6'b000011);
    clear_entry("t4 clear");
    digit(1'b1, "t4 d3");
    press(M_CLR | M_E1);
    dq.delete();
    chk("clear over digit", led, 0);
    enter_bits(45, 6, "pw digit");
    confirm_step(M_CONF | M_E1, "confirm over digit");

    // authenticate and switch to code 001
    select_btn("select");
    digit(1'b1, "auth d");
    select_btn("select ignored");
    clear_entry("auth clear");
    enter_bits(45, 6, "auth digit");
    confirm_step(M_CONF, "auth");
    chk("mode_sel led", led, 6'b110000);
    digit(1'b0, "code d0");
    digit(1'b0, "code d1");
    digit(1'b1, "code d2");
    confirm_step(M_CONF, "set code");
    enter_bits(52, 6, "new pw digit");
    confirm_step(M_CONF, "new pw");
    enter_bits(45, 6, "old pw digit");
    confirm_step(M_CONF, "old pw");

    // simultaneous enter1+enter0 gives a single 1
    press(M_E1 | M_E0);
    push_digit(1'b1);
    chk("both digits", led, exp_entry_led());
    enter_bits(20, 5, "pw tail digit");
    confirm_step(M_CONF, "pw after both");

    // seven digits in SEL_AUTH: last six are 101010
    select_btn("select 7");
    enter_bits(106, 7, "seven digit");
    confirm_step(M_CONF, "seven digits");

    // reset mid-entry restores code 000 and zero failures
    select_btn("select pre-reset");
    enter_bits(5, 3, "pre-reset digit");
    reset = 1'b1;
    @(negedge clock);
    chk("reset mid-op", led, 0);
    reset = 1'b0;
    dq.delete();
    m_code = 0;
    m_fail = 0;
    m_sel_auth = 1'b0;
    m_mode_sel = 1'b0;
    enter_bits(63, 6, "post-reset bad");
    confirm_step(M_CONF, "post-reset fail");
    enter_bits(45, 6, "post-reset pw");
    confirm_step(M_CONF, "post-reset pass");

    // randomized code selection and probes
    for (int it = 0; it < 5; it++) begin
      extra = $urandom_range(0, 2);
      kind  = $urandom_range(0, 2);
      select_btn("rnd select");
      enter_bits($urandom_range(0, 3), extra, "rnd junk");
      enter_bits(pw_tab[m_code], 6, "rnd auth digit");
      confirm_step(M_CONF, "rnd auth");
      if (kind == 2) begin
        nd = $urandom_range(0, 2);
        v  = $urandom_range(0, 3);
      end else begin
        nd = $urandom_range(3, 5);
        v  = $urandom_range(0, 31);
        v  = (kind == 0) ? (v & ~32'd4) : (v | 32'd4);
      end
      enter_bits(v, nd, "rnd code digit");
      confirm_step(M_CONF, "rnd code");
      if ($urandom_range(0, 1) == 1) v = pw_tab[m_code];
      else v = $urandom_range(0, 63);
      enter_bits(v, 6, "rnd probe digit");
      confirm_step(M_CONF, "rnd probe");
    end

    // inactivity in SEL_AUTH: timer restarted by last digit, 3 cycles before press returns
    select_btn("to select");
    digit(1'b1, "to d1");
    digit(1'b0, "to d2");
    hold_check(6'b000011, TO_T * FRE - 3, "sel_auth inactivity", 1'b0);
    hold_check(L_TO, TOS_T * FRE, "sel_auth timeout display", 1'b0);
    m_sel_auth = 1'b0;
    dq.delete();
    chk("idle after sel_auth timeout", led, 0);
    enter_bits(pw_tab[m_code], 6, "code kept digit");
    confirm_step(M_CONF, "code kept");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
